// File: rtl/vc32_mem_target.sv
// vc32_mem_target: memory/peripheral responder for the vc32 external byte bus.
// The CPU builds a 22-bit byte address over three latch phases (sampled on the
// falling clock edge). Reads are combinational. Writes commit on the rising edge.
// A 16-bit debug log register at 0x00FFFE/0x00FFFF feeds a small FIFO.
module vc32_mem_target #(
    parameter int ADDR_W    = 12,
    parameter int LOG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        bus_data,
    input  logic              bus_ind,
    input  logic              bus_write,
    input  logic              bus_latch_hi,
    input  logic              bus_latch_lo,
    output logic [7:0]        bus_rdata,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              log_valid,
    output logic [15:0]       log_data,
    input  logic              log_ready,
    output logic              log_ovf
);

    localparam int PTR_W = $clog2(LOG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Half-word address A[21:1]; bit 0 comes straight from bus_ind.
    logic [21:1]       addr_reg;
    logic [21:0]       byte_addr;
    logic              log_win;
    logic              in_win;
    logic [ADDR_W-1:0] mem_idx;

    logic [7:0]        mem [2**ADDR_W];

    logic              bus_mem_wr;
    logic              ld_blocked;

    // Log FIFO state
    logic [15:0]       fifo_mem [LOG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [7:0]        byte0_reg;
    logic              ovf_reg;
    logic              fifo_full;
    logic              log_push;
    logic              log_pop;
    logic              push_ok;

    assign byte_addr  = {addr_reg, bus_ind};
    assign log_win    = (addr_reg == 21'h007FFF);
    assign in_win     = (byte_addr[21:ADDR_W] == '0) && !log_win;
    assign mem_idx    = byte_addr[ADDR_W-1:0];

    // Reads are purely combinational; the log window and out-of-window read as zero.
    assign bus_rdata  = in_win ? mem[mem_idx] : 8'h00;

    // Address phases are captured on the falling edge so the following rising
    // edge (write commit / CPU sample) already sees the new address.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= '0;
        end else if (bus_latch_hi && !bus_latch_lo) begin
            addr_reg[21:16] <= bus_data[5:0];
        end else if (bus_latch_hi && bus_latch_lo) begin
            addr_reg[15:8] <= bus_data;
        end else if (bus_latch_lo) begin
            addr_reg[7:1] <= bus_data[7:1];
        end
    end

    assign bus_mem_wr = bus_write && in_win;
    // A bus write to the same byte on the same edge takes priority over the backdoor.
    assign ld_blocked = bus_mem_wr && (ld_addr == mem_idx);

    // Byte array: bus write port plus backdoor preload port; writes during reset are lost.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (bus_mem_wr) begin
                mem[mem_idx] <= bus_data;
            end
            if (ld_en && !ld_blocked) begin
                mem[ld_addr] <= ld_data;
            end
        end
    end

    assign fifo_full = (count_reg == CNT_W'(LOG_DEPTH));
    assign log_valid = (count_reg != '0);
    assign log_pop   = log_valid && log_ready;
    assign log_push  = bus_write && log_win && bus_ind;
    // A push into a full FIFO is only accepted when the head leaves on the same edge.
    assign push_ok   = log_push && (!fifo_full || log_pop);
    assign log_data  = log_valid ? fifo_mem[rd_ptr_reg] : 16'h0000;
    assign log_ovf   = ovf_reg;

    // Log FIFO storage; no reset needed since entries are only read while valid.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            fifo_mem[wr_ptr_reg] <= {bus_data, byte0_reg};
        end
    end

    // Log low-byte holding register, FIFO pointers/occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte0_reg  <= 8'h00;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (bus_write && log_win && !bus_ind) begin
                byte0_reg <= bus_data;
            end
            if (log_push && !push_ok) begin
                ovf_reg <= 1'b1;
            end
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (log_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push_ok && !log_pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (!push_ok && log_pop) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

endmodule
